otter_mem_port_arbiter: RTL

//  Shares one single-ported OTTER memory between the IF stage (read-only) and the MEM stage (read/write).

---
 rtl/otter_mem_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/otter_mem_port_arbiter.sv
// Arbiter sharing one single-ported OTTER memory between the fetch stage (read-only) and the
// MEM stage (read/write). One transaction is in flight at a time. DM normally wins, but only
// for a bounded run of grants while IF is waiting, so IF cannot starve.
module otter_mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  // fetch side
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_VALID,
  output logic              IF_STALL,
  // data side
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  input  logic [1:0]        DM_SIZE,
  input  logic              DM_SIGN,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              DM_VALID,
  output logic              DM_STALL,
  // memory side
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [1:0]        MEM_SIZE,
  output logic              MEM_SIGN,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              ERR_ACK
);

  localparam int unsigned StreakW = $clog2(MAX_DM_STREAK + 1);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

  state_e              state_q, state_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic                mem_sign_q, mem_sign_d;
  logic                err_ack_q, err_ack_d;

  logic                streak_sat;
  logic                dm_win;
  logic                if_win;

  assign streak_sat = (streak_q == StreakW'(MAX_DM_STREAK));

  // Grant decision: DM (older instruction) first unless IF has waited out a full streak.
  always_comb begin
    dm_win = DM_REQ & ~(IF_REQ & streak_sat);
    if_win = IF_REQ & ~dm_win;
  end

  // Next-state logic: grant in idle, hold the latched request until the memory acks.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_sign_d  = mem_sign_q;
    err_ack_d   = err_ack_q;

    unique case (state_q)
      StIdle: begin
        // An ack with nothing outstanding (e.g. left over from before a reset) is an error.
        if (MEM_ACK) begin
          err_ack_d = 1'b1;
        end
        if (dm_win) begin
          state_d     = StBusyDm;
          mem_req_d   = 1'b1;
          mem_we_d    = DM_WE;
          mem_addr_d  = DM_ADDR;
          mem_wdata_d = DM_WDATA;
          mem_size_d  = DM_SIZE;
          mem_sign_d  = DM_SIGN;
          if (IF_REQ && !streak_sat) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (if_win) begin
          state_d     = StBusyIf;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = IF_ADDR;
          mem_wdata_d = '0;
          mem_size_d  = 2'b10;
          mem_sign_d  = 1'b0;
          streak_d    = '0;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      StBusyIf, StBusyDm: begin
        if (MEM_ACK) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-side request fields.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= 2'b00;
      mem_sign_q  <= 1'b0;
      err_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_sign_q  <= mem_sign_d;
      err_ack_q   <= err_ack_d;
    end
  end

  // Completion is returned combinationally in the ack cycle; stores return zero data.
  always_comb begin
    IF_VALID  = (state_q == StBusyIf) & MEM_ACK;
    DM_VALID  = (state_q == StBusyDm) & MEM_ACK;
    IF_RDATA  = IF_VALID ? MEM_RDATA : '0;
    DM_RDATA  = (DM_VALID & ~mem_we_q) ? MEM_RDATA : '0;
    IF_STALL  = IF_REQ & ~IF_VALID;
    DM_STALL  = DM_REQ & ~DM_VALID;
    MEM_REQ   = mem_req_q;
    MEM_WE    = mem_we_q;
    MEM_ADDR  = mem_addr_q;
    MEM_WDATA = mem_wdata_q;
    MEM_SIZE  = mem_size_q;
    MEM_SIGN  = mem_sign_q;
    ERR_ACK   = err_ack_q;
  end

endmodule
